// File: rtl/io_port_unit.sv
// io_port_unit: memory-mapped I/O beside the cpu: DATA/STATUS window, TX FIFO to a valid/ready port, sampled input port.
// Define IO_PORT_UNIT_SYNC_EN to put a two-flop synchroniser on i_w_port_in; otherwise it is sampled by a single register.
module io_port_unit #(
   parameter int p_data_width = 16,
   parameter int p_address_width = 10,
   parameter int p_port_width = 8,
   parameter int p_fifo_depth = 4,
   parameter logic [p_address_width-1:0] p_base_address = 10'h3F0
) (
   input  logic                       i_w_clk,
   input  logic                       i_w_reset,
   input  logic [p_address_width-1:0] i_w_address,
   input  logic [p_data_width-1:0]    i_w_data,
   input  logic                       i_w_wr,
   input  logic                       i_w_rd,
   output logic [p_data_width-1:0]    o_w_io_out,
   output logic [p_port_width-1:0]    o_w_port_data,
   output logic                       o_w_port_valid,
   input  logic                       i_w_port_ready,
   input  logic [p_port_width-1:0]    i_w_port_in
);
   localparam int lp_ptr_w = $clog2(p_fifo_depth);
   localparam int lp_cnt_w = lp_ptr_w + 1;
   localparam logic [p_address_width-1:0] lp_stat_address =
      p_base_address + {{(p_address_width-1){1'b0}}, 1'b1};

   logic [p_port_width-1:0] mem_q [p_fifo_depth];
   logic [p_port_width-1:0] mem_d [p_fifo_depth];
   logic [lp_ptr_w-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [lp_cnt_w-1:0]     count_q, count_d;
   logic                    overflow_q, overflow_d;
   logic [p_data_width-1:0] io_out_q, io_out_d;
   logic [p_port_width-1:0] port_in_q, port_in_d;
   logic [p_data_width-1:0] status;
   logic                    sel_data, sel_stat, full, empty, pop, push_req, push;

   always_comb begin
      sel_data = i_w_address == p_base_address;
      sel_stat = i_w_address == lp_stat_address;
      full     = count_q == lp_cnt_w'(p_fifo_depth);
      empty    = count_q == '0;
      pop      = !empty && i_w_port_ready;
      push_req = i_w_wr && sel_data;
      push     = push_req && (!full || pop);
      status   = {{(p_data_width-8-lp_cnt_w){1'b0}}, count_q, 5'b0, overflow_q, empty, full};
      mem_d    = mem_q;
      if (push) mem_d[wr_ptr_q] = i_w_data[p_port_width-1:0];
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + lp_cnt_w'(push) - lp_cnt_w'(pop);
      // a fresh overflow wins over the clear-on-read of STATUS
      overflow_d = (push_req && full && !pop) || (overflow_q && !(i_w_rd && sel_stat));
      io_out_d = !i_w_rd ? io_out_q :
                 sel_data ? {{(p_data_width-p_port_width){1'b0}}, port_in_q} :
                 sel_stat ? status : '0;
   end

`ifdef IO_PORT_UNIT_SYNC_EN
   logic [p_port_width-1:0] meta_q;
   always_ff @(posedge i_w_clk or posedge i_w_reset)
      if (i_w_reset) meta_q <= '0;
      else meta_q <= i_w_port_in;
   assign port_in_d = meta_q;
`else
   assign port_in_d = i_w_port_in;
`endif

   always_ff @(posedge i_w_clk or posedge i_w_reset) begin
      if (i_w_reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         io_out_q   <= '0;
         port_in_q  <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         io_out_q   <= io_out_d;
         port_in_q  <= port_in_d;
      end
   end

   // storage needs no reset: it is only observed while count is non-zero
   always_ff @(posedge i_w_clk) mem_q <= mem_d;

   assign o_w_io_out     = io_out_q;
   assign o_w_port_valid = !empty;
   assign o_w_port_data  = empty ? '0 : mem_q[rd_ptr_q];
endmodule
